str_stream_splitter: RTL and testbench
======================================

// Module: str_stream_splitter
// PURPOSE
//  Streaming hardware tokenizer: splits a byte stream on any of NumDelims programmable delimiters,
//  honouring double-quote grouping and optionally stripping leading/trailing whitespace per token.
//  Sits between a DMA/byte-stream source and firmware-visible token consumers (log/cmd parsers).
//  Tokens are emitted byte-serially with an end-of-token marker; empty tokens are dropped.
// PARAMETERS
//  NumDelims   4  number of delimiter byte slots (unused slots disabled via delim_en_i)
//  WsBufDepth  8  pending-whitespace buffer depth (bytes); >=2
//  TokCntW     16 width of per-stream token counter (saturating)
// PORTS
//  clk_i        in  1             clock
//  rst_ni       in  1             asynchronous active-low reset
//  delim_i      in  8*NumDelims   delimiter bytes, slot k = [8k+:8]; quasi-static while busy
//  delim_en_i   in  NumDelims     per-slot enable
//  strip_en_i   in  1             strip whitespace (0x20,0x09,0x0A) at both token ends
//  quote_en_i   in  1             '"' (0x22) toggles quoted mode; delimiters/ws literal inside
//  in_valid_i   in  1             input byte valid
//  in_ready_o   out 1             input byte accepted when valid&ready
//  in_data_i    in  8             input byte
//  in_last_i    in  1             byte is last of stream
//  out_valid_o  out 1             token byte valid
//  out_ready_i  in  1             consumer ready
//  out_data_o   out 8             token byte
//  out_last_o   out 1             final byte of current token
//  tok_count_o  out TokCntW       tokens completed in current stream
//  done_o       out 1             1-cycle pulse: final token byte of stream accepted (or empty stream ended)
//  ws_ovf_o     out 1             sticky: whitespace buffer overflowed since reset
// BEHAVIOUR
//  Reset: all outputs 0, in_ready_o 0 during reset then 1; state IDLE; buffers empty; quote flag 0.
//  Classification of accepted byte b (quote flag q): QUOTE if quote_en_i & b==0x22 (toggles q, byte
//   is data); DELIM if !q & b matches any enabled slot; WS if strip_en_i & !q & b in ws set; else DATA.
//  One-byte hold register H gives lookahead: a byte is presented on out_* only once its out_last_o
//   value is known. Output regs change only when !out_valid_o | out_ready_i (AXI-style stable hold).
//  States:
//   IDLE  : between tokens. WS/DELIM discarded. DATA/QUOTE -> load H, goto TOK.
//   TOK   : DATA/QUOTE with ws buf empty -> emit H (last=0), load b into H.
//           DATA/QUOTE with ws buf non-empty -> goto FLUSH (b captured in pending reg, in_ready_o=0).
//           WS -> push to ws buf; if full -> ws_ovf_o=1, goto FLUSH (buffer committed as data), b pushed after.
//           DELIM -> ws buf cleared (trailing ws dropped), H emitted with last=1, tok_count++, goto IDLE.
//   FLUSH : in_ready_o=0; each output handshake emits H then pops ws buf into H; when empty, pending
//           byte -> H, return TOK. Throughput 1 byte/cycle when out_ready_i=1.
//   Stream end (in_last_i accepted): byte processed as above, then treated as DELIM; q cleared;
//   done_o pulses on acceptance of final token byte, or the cycle after in_last_i if no token pending.
//  Latency: first token byte appears >=2 cycles after acceptance (needs next byte or delimiter).
//  tok_count_o saturates at all-ones; cleared on first byte accepted after done_o.
//  Back-pressure: out_ready_i=0 stalls in_ready_o once H is occupied and a new byte needs H; no loss.
//  Unterminated quote at stream end: token closed normally, no error.
//  Async reset mid-token: partial token discarded, no out_last_o emitted.
// STRUCTURE
//  str_stream_pkg: ws char constants, QUOTE_CHAR, byte_class_e, splitter_state_e, class function.
//  Sub-module str_ws_fifo: sync byte FIFO (WsBufDepth) with push/pop/clear/full/empty.
//  Top: classifier (comb), FSM, H register + pending register, counters.
// TESTING
//  strip=1, delim ',': "  a, b ,c  "+last -> tokens "a","b","c"; count 3; one done_o pulse.
//  quote_en=1: x,"a, b",y -> x | "a, b" | y (quotes kept, inner space kept).
//  ",,a,,"+last -> single token "a"; count 1. Empty stream (only ",") -> count 0, done_o pulse.
//  WsBufDepth=4: "a"+6 spaces+"," -> token "a"+4 spaces; ws_ovf_o=1 sticky until reset.
//  Random out_ready_i (50%), 2 delims ',',';' enabled -> byte stream equals reference model, no drops.
//  Reset asserted mid-"hello": outputs 0, next stream "ok"+last -> "ok", count 1.

Source files
------------

// File: rtl/str_stream_pkg.sv
// Shared types and byte classification for the streaming tokenizer.
package str_stream_pkg;

   localparam logic [7:0] QUOTE_CHAR = 8'h22;
   localparam logic [7:0] WS_SPACE   = 8'h20;
   localparam logic [7:0] WS_TAB     = 8'h09;
   localparam logic [7:0] WS_LF      = 8'h0a;

   typedef enum logic [1:0] {ClsData, ClsQuote, ClsDelim, ClsWs} byte_class_e;

   typedef enum logic [1:0] {StIdle, StTok, StFlush, StClose} splitter_state_e;

   function automatic logic is_ws(input logic [7:0] b);
      return (b == WS_SPACE) || (b == WS_TAB) || (b == WS_LF);
   endfunction

   // A quote byte is always data and takes precedence over a delimiter slot holding 0x22.
   function automatic byte_class_e classify(input logic [7:0] b, input logic quote_q,
                                            input logic strip_en, input logic quote_en,
                                            input logic delim_hit);
      if (quote_en && b == QUOTE_CHAR) return ClsQuote;
      if (!quote_q && delim_hit) return ClsDelim;
      if (strip_en && !quote_q && is_ws(b)) return ClsWs;
      return ClsData;
   endfunction

endpackage

// File: rtl/str_ws_fifo.sv
// Small synchronous byte FIFO holding whitespace that may turn out to be trailing.
module str_ws_fifo #(
   parameter int unsigned Depth = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [7:0]      mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] cnt_q;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o && !clr_i;
   assign do_pop  = pop_i && !empty_o && !clr_i;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (do_push && !do_pop) cnt_q <= cnt_q + CntW'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/str_stream_splitter.sv
// Streaming tokenizer: splits bytes on programmable delimiters with quoting and
// optional whitespace stripping; emits token bytes with an end-of-token marker.
module str_stream_splitter
   import str_stream_pkg::*;
#(
   parameter int unsigned NumDelims  = 4,
   parameter int unsigned WsBufDepth = 8,
   parameter int unsigned TokCntW    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [8*NumDelims-1:0] delim_i,
   input  logic [NumDelims-1:0]   delim_en_i,
   input  logic                   strip_en_i,
   input  logic                   quote_en_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [7:0]             in_data_i,
   input  logic                   in_last_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [7:0]             out_data_o,
   output logic                   out_last_o,
   output logic [TokCntW-1:0]     tok_count_o,
   output logic                   done_o,
   output logic                   ws_ovf_o
);

   splitter_state_e state_q, state_d;
   logic [7:0]   h_q, h_d, pend_q, pend_d;
   logic         pend_ws_q, pend_ws_d, pend_last_q, pend_last_d;
   logic         quote_q, rdy_q, ovf_q, done_q, after_done_q;
   logic         out_valid_q, out_last_q, out_end_q;
   logic [7:0]   out_data_q;
   logic [TokCntW-1:0] tok_cnt_q;

   logic         delim_hit, out_free, accept;
   byte_class_e  cls;
   logic         out_load, out_d_last, out_d_end, tok_inc, ovf_set, end_empty, done_d;
   logic         ws_push, ws_pop, ws_clr, ws_full, ws_empty;
   logic [7:0]   ws_wdata, ws_rdata;

   always_comb begin
      delim_hit = 1'b0;
      for (int k = 0; k < int'(NumDelims); k++) begin
         if (delim_en_i[k] && delim_i[8*k +: 8] == in_data_i) delim_hit = 1'b1;
      end
   end

   assign cls      = classify(in_data_i, quote_q, strip_en_i, quote_en_i, delim_hit);
   assign out_free = !out_valid_q || out_ready_i;
   assign accept   = in_valid_i && in_ready_o;

   // Idle holds off a new stream until the previous stream's final byte is taken,
   // so done_o and the count clear stay ordered.
   always_comb begin
      in_ready_o = 1'b0;
      if (rdy_q) begin
         case (state_q)
            StIdle:  in_ready_o = !(out_valid_q && out_end_q);
            StTok:   in_ready_o = out_free;
            default: in_ready_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      pend_d      = pend_q;
      pend_ws_d   = pend_ws_q;
      pend_last_d = pend_last_q;
      out_load    = 1'b0;
      out_d_last  = 1'b0;
      out_d_end   = 1'b0;
      tok_inc     = 1'b0;
      ovf_set     = 1'b0;
      end_empty   = 1'b0;
      ws_push     = 1'b0;
      ws_pop      = 1'b0;
      ws_clr      = 1'b0;
      ws_wdata    = in_data_i;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (cls == ClsData || cls == ClsQuote) begin
                  h_d     = in_data_i;
                  state_d = in_last_i ? StClose : StTok;
               end else if (in_last_i) begin
                  end_empty = 1'b1;
               end
            end
         end
         StTok: begin
            if (accept) begin
               unique case (cls)
                  ClsData, ClsQuote: begin
                     if (ws_empty) begin
                        out_load = 1'b1;
                        h_d      = in_data_i;
                        state_d  = in_last_i ? StClose : StTok;
                     end else begin
                        pend_d      = in_data_i;
                        pend_ws_d   = 1'b0;
                        pend_last_d = in_last_i;
                        state_d     = StFlush;
                     end
                  end
                  ClsWs: begin
                     if (ws_full) begin
                        ovf_set     = 1'b1;
                        pend_d      = in_data_i;
                        pend_ws_d   = 1'b1;
                        pend_last_d = in_last_i;
                        state_d     = StFlush;
                     end else if (in_last_i) begin
                        ws_clr     = 1'b1;
                        out_load   = 1'b1;
                        out_d_last = 1'b1;
                        out_d_end  = 1'b1;
                        tok_inc    = 1'b1;
                        state_d    = StIdle;
                     end else begin
                        ws_push = 1'b1;
                     end
                  end
                  ClsDelim: begin
                     ws_clr     = 1'b1;
                     out_load   = 1'b1;
                     out_d_last = 1'b1;
                     out_d_end  = in_last_i;
                     tok_inc    = 1'b1;
                     state_d    = StIdle;
                  end
               endcase
            end
         end
         StFlush: begin
            // Overflowed whitespace: once the committed bytes are out, the pending
            // blank starts a fresh trailing run.
            if (ws_empty && pend_ws_q) begin
               if (pend_last_q) begin
                  state_d = StClose;
               end else begin
                  ws_push  = 1'b1;
                  ws_wdata = pend_q;
                  state_d  = StTok;
               end
            end else if (out_free) begin
               out_load = 1'b1;
               if (!ws_empty) begin
                  ws_pop = 1'b1;
                  h_d    = ws_rdata;
               end else begin
                  h_d     = pend_q;
                  state_d = pend_last_q ? StClose : StTok;
               end
            end
         end
         StClose: begin
            if (out_free) begin
               out_load   = 1'b1;
               out_d_last = 1'b1;
               out_d_end  = 1'b1;
               tok_inc    = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign done_d = (out_valid_q && out_ready_i && out_last_q && out_end_q) || end_empty;

   str_ws_fifo #(
      .Depth (WsBufDepth)
   ) u_ws_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (ws_clr),
      .push_i  (ws_push),
      .data_i  (ws_wdata),
      .pop_i   (ws_pop),
      .data_o  (ws_rdata),
      .full_o  (ws_full),
      .empty_o (ws_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         h_q          <= '0;
         pend_q       <= '0;
         pend_ws_q    <= 1'b0;
         pend_last_q  <= 1'b0;
         quote_q      <= 1'b0;
         rdy_q        <= 1'b0;
         ovf_q        <= 1'b0;
         done_q       <= 1'b0;
         after_done_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_end_q    <= 1'b0;
         tok_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         pend_q      <= pend_d;
         pend_ws_q   <= pend_ws_d;
         pend_last_q <= pend_last_d;
         rdy_q       <= 1'b1;
         done_q      <= done_d;
         if (ovf_set) ovf_q <= 1'b1;
         if (accept) begin
            if (in_last_i) quote_q <= 1'b0;
            else if (cls == ClsQuote) quote_q <= !quote_q;
         end
         if (done_d) after_done_q <= 1'b1;
         else if (accept) after_done_q <= 1'b0;
         if (accept && after_done_q) tok_cnt_q <= '0;
         else if (tok_inc && tok_cnt_q != '1) tok_cnt_q <= tok_cnt_q + TokCntW'(1);
         if (out_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= h_q;
            out_last_q  <= out_d_last;
            out_end_q   <= out_d_end;
         end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign tok_count_o = tok_cnt_q;
   assign done_o      = done_q;
   assign ws_ovf_o    = ovf_q;

endmodule

// File: tb/tb_str_stream_splitter.sv
// Scoreboard bench for str_stream_splitter: token-level reference model feeds an
// expected-byte queue that a free-running monitor checks against the output port.
module tb_str_stream_splitter;

   localparam int unsigned ND = 4;
   localparam int unsigned WD = 4;
   localparam int unsigned CW = 16;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {logic [7:0] data; logic last;} ob_t;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [8*ND-1:0] delim_i = '0;
   logic [ND-1:0]   delim_en_i = '0;
   logic            strip_en_i = 1'b0;
   logic            quote_en_i = 1'b0;
   logic            in_valid_i = 1'b0;
   logic            in_ready_o;
   logic [7:0]      in_data_i = '0;
   logic            in_last_i = 1'b0;
   logic            out_valid_o;
   logic            out_ready_i = 1'b1;
   logic [7:0]      out_data_o;
   logic            out_last_o;
   logic [CW-1:0]   tok_count_o;
   logic            done_o;
   logic            ws_ovf_o;

   always #5 clk_i = ~clk_i;

   str_stream_splitter #(
      .NumDelims  (ND),
      .WsBufDepth (WD),
      .TokCntW    (CW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .delim_i     (delim_i),
      .delim_en_i  (delim_en_i),
      .strip_en_i  (strip_en_i),
      .quote_en_i  (quote_en_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o),
      .tok_count_o (tok_count_o),
      .done_o      (done_o),
      .ws_ovf_o    (ws_ovf_o)
   );

   ob_t         exp_q[$];
   int unsigned exp_cnt_q[$];
   int          total = 0;
   int          bad = 0;
   int          done_seen = 0;
   int          streams = 0;
   bit          mon_ignore = 0;
   bit          ign_last = 0;
   bit          rand_ready = 0;
   ob_t         e;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   function automatic bq_t str2q(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Token-level model: split, strip blanks at token edges, commit blank runs that
   // outgrow the buffer, drop empty tokens.
   function automatic void model(input bq_t s);
      bq_t tok, pws;
      bit  q, in_tok, isq, isd, isw;
      int  ntok;
      logic [7:0] b;
      q = 0; in_tok = 0; ntok = 0;
      for (int i = 0; i <= s.size(); i++) begin
         if (i == s.size()) begin
            isd = 1; isq = 0; isw = 0; b = 8'h00;
         end else begin
            b   = s[i];
            isq = quote_en_i && b == 8'h22;
            isd = 0;
            for (int k = 0; k < int'(ND); k++)
               if (delim_en_i[k] && delim_i[8*k +: 8] == b) isd = 1;
            isd = isd && !q && !isq;
            isw = strip_en_i && !q && !isq && !isd && (b == 8'h20 || b == 8'h09 || b == 8'h0a);
            if (isq) q = !q;
         end
         if (isd) begin
            if (in_tok) begin
               for (int j = 0; j < tok.size(); j++)
                  exp_q.push_back('{data: tok[j], last: (j == tok.size() - 1)});
               ntok++;
            end
            in_tok = 0; tok.delete(); pws.delete();
         end else if (isw) begin
            if (in_tok) begin
               if (pws.size() == WD) begin
                  foreach (pws[j]) tok.push_back(pws[j]);
                  pws.delete();
               end
               pws.push_back(b);
            end
         end else begin
            foreach (pws[j]) tok.push_back(pws[j]);
            pws.delete();
            tok.push_back(b);
            in_tok = 1;
         end
      end
      exp_cnt_q.push_back(ntok);
   endfunction

   // Entered and left at posedge+1.
   task automatic send(input bq_t s, input bit with_last);
      int n;
      for (int i = 0; i < s.size(); i++) begin
         in_valid_i = 1'b1;
         in_data_i  = s[i];
         in_last_i  = with_last && (i == s.size() - 1);
         n = 0;
         @(negedge clk_i);
         while (!in_ready_o && n < 1000) begin
            n++;
            @(negedge clk_i);
         end
         if (!in_ready_o) begin
            $display("FAIL in_ready_timeout: got 0 expected 1");
            bad++; total++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "stalled input");
         end
         @(posedge clk_i); #1;
         in_valid_i = 1'b0;
         in_last_i  = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
         end
      end
   endtask

   task automatic run_stream(input bq_t s);
      model(s);
      streams++;
      send(s, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || exp_cnt_q.size() != 0) && n < 5000) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("drain_left_bytes", exp_q.size(), 0);
      check("drain_left_dones", exp_cnt_q.size(), 0);
      repeat (4) @(posedge clk_i);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk_i); #1;
         out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (out_valid_o && out_ready_i) begin
            if (mon_ignore) begin
               if (out_last_o) ign_last = 1;
            end else if (exp_q.size() == 0) begin
               check("unexpected_out_byte", {out_data_o, out_last_o}, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_data", out_data_o, e.data);
               check("out_last", out_last_o, e.last);
            end
         end
         if (done_o) begin
            done_seen++;
            if (exp_cnt_q.size() == 0) check("unexpected_done", 1, 0);
            else check("tok_count_at_done", tok_count_o, exp_cnt_q.pop_front());
         end
      end
   end

   initial begin
      bq_t s;
      string alpha;
      alpha = "abc,; \t\"x\n";
      @(negedge clk_i);
      check("rst_in_ready", in_ready_o, 0);
      check("rst_out_valid", out_valid_o, 0);
      check("rst_tok_count", tok_count_o, 0);
      check("rst_done", done_o, 0);
      check("rst_ws_ovf", ws_ovf_o, 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_in_ready", in_ready_o, 1);
      @(posedge clk_i); #1;

      delim_i    = {8'h00, 8'h00, 8'h00, 8'h2c};
      delim_en_i = 4'b0001;
      strip_en_i = 1'b1;
      run_stream(str2q("  a, b ,c  "));
      drain();

      quote_en_i = 1'b1;
      run_stream(str2q("x,\"a, b\",y"));
      drain();

      quote_en_i = 1'b0;
      strip_en_i = 1'b0;
      run_stream(str2q(",,a,,"));
      drain();
      run_stream(str2q(","));
      drain();

      check("ws_ovf_before", ws_ovf_o, 0);
      strip_en_i = 1'b1;
      run_stream(str2q("a      ,"));
      drain();
      check("ws_ovf_set", ws_ovf_o, 1);

      delim_i    = {8'h78, 8'h61, 8'h3b, 8'h2c};
      delim_en_i = 4'b0011;
      rand_ready = 1;
      for (int t = 0; t < 40; t++) begin
         s.delete();
         for (int i = 0; i < int'($urandom_range(1, 24)); i++)
            s.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
         strip_en_i = 1'($urandom_range(0, 1));
         quote_en_i = 1'($urandom_range(0, 1));
         run_stream(s);
         drain();
      end
      rand_ready = 0;
      check("ws_ovf_sticky", ws_ovf_o, 1);
      check("done_count", done_seen, streams);

      delim_i    = {8'h00, 8'h00, 8'h00, 8'h2c};
      delim_en_i = 4'b0001;
      strip_en_i = 1'b0;
      quote_en_i = 1'b0;
      mon_ignore = 1;
      send(str2q("hello"), 1'b0);
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b0;
      @(negedge clk_i);
      check("midrst_out_valid", out_valid_o, 0);
      check("midrst_in_ready", in_ready_o, 0);
      check("midrst_ws_ovf", ws_ovf_o, 0);
      check("midrst_tok_count", tok_count_o, 0);
      check("midrst_no_last", ign_last, 0);
      rst_ni = 1'b1;
      mon_ignore = 0;
      @(posedge clk_i); #1;
      run_stream(str2q("ok"));
      drain();
      check("final_done_count", done_seen, streams);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
